// File: rtl/lrn_glb_arbiter.sv
// Arbitrates the single-port LRN GLB bank between mapper read, mapper write and padding write.
// Define LRN_ARB_FIXED_PRIO_EN for fixed priority (wr > pad > rd) instead of round-robin.
module lrn_glb_arbiter #(
    parameter int unsigned ADDR_BUS_WIDTH = 20,
    parameter int unsigned DATA_WIDTH     = 16,
    parameter int unsigned RD_LATENCY     = 1
) (
    input  logic                      core_clk,
    input  logic                      reset_n,
    input  logic                      rd_req,
    input  logic [ADDR_BUS_WIDTH-1:0] rd_addr,
    output logic                      rd_gnt,
    output logic                      rd_data_valid,
    output logic [DATA_WIDTH-1:0]     rd_data,
    input  logic                      wr_req,
    input  logic [ADDR_BUS_WIDTH-1:0] wr_addr,
    input  logic [DATA_WIDTH-1:0]     wr_data,
    output logic                      wr_gnt,
    input  logic                      pad_req,
    input  logic [ADDR_BUS_WIDTH-1:0] pad_addr,
    input  logic [DATA_WIDTH-1:0]     pad_data,
    output logic                      pad_gnt,
    input  logic                      freeze,
    output logic                      idle,
    output logic                      glb_en,
    output logic                      glb_we,
    output logic [ADDR_BUS_WIDTH-1:0] glb_addr,
    output logic [DATA_WIDTH-1:0]     glb_wdata,
    input  logic [DATA_WIDTH-1:0]     glb_rdata
);

    localparam int unsigned TOK_DEPTH = RD_LATENCY + 1;

    logic [2:0]           req_c;
    logic [2:0]           gnt_c;
    logic                 arb_en_c;
    logic [TOK_DEPTH-1:0] rd_tok;

    assign req_c    = {pad_req, wr_req, rd_req};
    // Grants are suppressed while frozen and while reset is asserted so reset outputs are clean.
    assign arb_en_c = reset_n & ~freeze;

`ifdef LRN_ARB_FIXED_PRIO_EN
    always_comb begin
        gnt_c = 3'b000;
        if (arb_en_c) begin
            if (req_c[1])      gnt_c = 3'b010;
            else if (req_c[2]) gnt_c = 3'b100;
            else if (req_c[0]) gnt_c = 3'b001;
        end
    end
`else
    logic [1:0] rr_ptr;
    logic [1:0] rr_ptr_nxt_c;

    // Search order starts at rr_ptr and wraps modulo 3.
    always_comb begin
        gnt_c = 3'b000;
        if (arb_en_c) begin
            case (rr_ptr)
                2'd0: begin
                    if (req_c[0])      gnt_c = 3'b001;
                    else if (req_c[1]) gnt_c = 3'b010;
                    else if (req_c[2]) gnt_c = 3'b100;
                end
                2'd1: begin
                    if (req_c[1])      gnt_c = 3'b010;
                    else if (req_c[2]) gnt_c = 3'b100;
                    else if (req_c[0]) gnt_c = 3'b001;
                end
                default: begin
                    if (req_c[2])      gnt_c = 3'b100;
                    else if (req_c[0]) gnt_c = 3'b001;
                    else if (req_c[1]) gnt_c = 3'b010;
                end
            endcase
        end
    end

    always_comb begin
        rr_ptr_nxt_c = rr_ptr;
        if (gnt_c[0])      rr_ptr_nxt_c = 2'd1;
        else if (gnt_c[1]) rr_ptr_nxt_c = 2'd2;
        else if (gnt_c[2]) rr_ptr_nxt_c = 2'd0;
    end

    always_ff @(posedge core_clk or negedge reset_n) begin
        if (!reset_n) rr_ptr <= 2'd0;
        else          rr_ptr <= rr_ptr_nxt_c;
    end
`endif

    assign rd_gnt  = gnt_c[0];
    assign wr_gnt  = gnt_c[1];
    assign pad_gnt = gnt_c[2];

    // Command register: winner is presented to the GLB the cycle after its grant.
    always_ff @(posedge core_clk or negedge reset_n) begin
        if (!reset_n) begin
            glb_en    <= 1'b0;
            glb_we    <= 1'b0;
            glb_addr  <= '0;
            glb_wdata <= '0;
        end else begin
            glb_en <= |gnt_c;
            if (gnt_c[0]) begin
                glb_we   <= 1'b0;
                glb_addr <= rd_addr;
            end else if (gnt_c[1]) begin
                glb_we    <= 1'b1;
                glb_addr  <= wr_addr;
                glb_wdata <= wr_data;
            end else if (gnt_c[2]) begin
                glb_we    <= 1'b1;
                glb_addr  <= pad_addr;
                glb_wdata <= pad_data;
            end
        end
    end

    // Read tokens: bit RD_LATENCY marks the cycle glb_rdata carries the returned word.
    always_ff @(posedge core_clk or negedge reset_n) begin
        if (!reset_n) begin
            rd_tok        <= '0;
            rd_data_valid <= 1'b0;
            rd_data       <= '0;
        end else begin
            if (TOK_DEPTH > 1) rd_tok <= TOK_DEPTH'({rd_tok, gnt_c[0]});
            else               rd_tok <= TOK_DEPTH'(gnt_c[0]);
            rd_data_valid <= rd_tok[RD_LATENCY];
            if (rd_tok[RD_LATENCY]) rd_data <= glb_rdata;
        end
    end

    // The returning word counts as in flight until its valid pulse has been presented.
    assign idle = ~|gnt_c & ~glb_en & ~|rd_tok & ~rd_data_valid;

endmodule

// File: tb/tb_lrn_glb_arbiter.sv
// Directed self-checking bench for lrn_glb_arbiter with a small latency-accurate SRAM model.
module tb_lrn_glb_arbiter;

    localparam int unsigned AW  = 20;
    localparam int unsigned DW  = 16;
    localparam int unsigned RDL = 3;

    logic          core_clk = 1'b0;
    logic          reset_n;
    logic          rd_req, wr_req, pad_req, freeze;
    logic [AW-1:0] rd_addr, wr_addr, pad_addr;
    logic [DW-1:0] wr_data, pad_data;
    logic          rd_gnt, wr_gnt, pad_gnt, rd_data_valid, idle;
    logic [DW-1:0] rd_data, glb_wdata, glb_rdata;
    logic          glb_en, glb_we;
    logic [AW-1:0] glb_addr;

    int n_checks = 0;
    int n_fail   = 0;

    logic [2:0] gnt_seq [6];
    logic       we_seq  [6];
    logic [DW-1:0] sram_pipe [RDL];

    always #5 core_clk = ~core_clk;

    lrn_glb_arbiter #(.ADDR_BUS_WIDTH(AW), .DATA_WIDTH(DW), .RD_LATENCY(RDL)) dut (
        .core_clk(core_clk), .reset_n(reset_n),
        .rd_req(rd_req), .rd_addr(rd_addr), .rd_gnt(rd_gnt),
        .rd_data_valid(rd_data_valid), .rd_data(rd_data),
        .wr_req(wr_req), .wr_addr(wr_addr), .wr_data(wr_data), .wr_gnt(wr_gnt),
        .pad_req(pad_req), .pad_addr(pad_addr), .pad_data(pad_data), .pad_gnt(pad_gnt),
        .freeze(freeze), .idle(idle),
        .glb_en(glb_en), .glb_we(glb_we), .glb_addr(glb_addr),
        .glb_wdata(glb_wdata), .glb_rdata(glb_rdata)
    );

    // SRAM model: word = 0x1224 + addr, valid RDL cycles after a read strobe, 0xDEAD otherwise.
    always @(posedge core_clk) begin
        sram_pipe[0] <= (glb_en && !glb_we) ? 16'h1224 + glb_addr[15:0] : 16'hDEAD;
        for (int i = 1; i < RDL; i++) sram_pipe[i] <= sram_pipe[i-1];
    end
    assign glb_rdata = sram_pipe[RDL-1];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge core_clk);
        #1;
    endtask

    task automatic mid();
        @(negedge core_clk);
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_glb_en"}, 32'(glb_en), 32'd0);
        chk({tag, "_glb_we"}, 32'(glb_we), 32'd0);
        chk({tag, "_glb_addr"}, 32'(glb_addr), 32'd0);
        chk({tag, "_glb_wdata"}, 32'(glb_wdata), 32'd0);
        chk({tag, "_rd_valid"}, 32'(rd_data_valid), 32'd0);
        chk({tag, "_rd_data"}, 32'(rd_data), 32'd0);
        chk({tag, "_idle"}, 32'(idle), 32'd1);
    endtask

    initial begin
`ifdef LRN_ARB_FIXED_PRIO_EN
        gnt_seq = '{3'b010, 3'b010, 3'b010, 3'b010, 3'b010, 3'b010};
        we_seq  = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1};
`else
        gnt_seq = '{3'b001, 3'b010, 3'b100, 3'b001, 3'b010, 3'b100};
        we_seq  = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1};
`endif
        reset_n = 1'b0; freeze = 1'b0;
        rd_req = 1'b0; wr_req = 1'b0; pad_req = 1'b0;
        rd_addr = '0; wr_addr = '0; pad_addr = '0; wr_data = '0; pad_data = '0;
        #2;
        chk_reset_outputs("reset");
        tick(); tick();
        reset_n = 1'b1;

        // Single read to 0x10.
        tick();
        rd_req = 1'b1; rd_addr = 20'h00010;
        mid();
        chk("single_gnt", 32'({pad_gnt, wr_gnt, rd_gnt}), 32'b001);
        chk("single_busy", 32'(idle), 32'd0);
        tick();
        rd_req = 1'b0;
        mid();
        chk("single_glb_en", 32'(glb_en), 32'd1);
        chk("single_glb_we", 32'(glb_we), 32'd0);
        chk("single_glb_addr", 32'(glb_addr), 32'h10);
        for (int c = 2; c <= RDL + 2; c++) begin
            tick(); mid();
            chk("single_valid", 32'(rd_data_valid), 32'(c == RDL + 2));
            if (c == RDL + 2) chk("single_data", 32'(rd_data), 32'h1234);
        end
        tick(); mid();
        chk("single_valid_drop", 32'(rd_data_valid), 32'd0);
        chk("single_data_hold", 32'(rd_data), 32'h1234);
        chk("single_idle", 32'(idle), 32'd1);

        // All three requesters held from reset.
        tick();
        reset_n = 1'b0;
        tick();
        reset_n = 1'b1;
        rd_req = 1'b1; rd_addr = 20'h00040;
        wr_req = 1'b1; wr_addr = 20'h00020; wr_data = 16'hBEEF;
        pad_req = 1'b1; pad_addr = 20'h00030; pad_data = 16'h0007;
        for (int i = 0; i <= 6; i++) begin
            if (i == 6) begin
                rd_req = 1'b0; wr_req = 1'b0; pad_req = 1'b0;
            end
            mid();
            if (i < 6) chk("rr_gnt", 32'({pad_gnt, wr_gnt, rd_gnt}), 32'(gnt_seq[i]));
            else       chk("rr_gnt_none", 32'({pad_gnt, wr_gnt, rd_gnt}), 32'd0);
            if (i > 0) begin
                chk("rr_glb_en", 32'(glb_en), 32'd1);
                chk("rr_glb_we", 32'(glb_we), 32'(we_seq[i-1]));
            end
            if (i == 2) begin
                chk("rr_wr_addr", 32'(glb_addr), 32'h20);
                chk("rr_wr_data", 32'(glb_wdata), 32'hBEEF);
            end
            tick();
        end
        mid();
        chk("rr_glb_en_off", 32'(glb_en), 32'd0);
`ifdef LRN_ARB_FIXED_PRIO_EN
        chk("rr_wdata_hold", 32'(glb_wdata), 32'hBEEF);
`else
        chk("rr_wdata_hold", 32'(glb_wdata), 32'h0007);
`endif
        repeat (RDL + 3) tick();
        mid();
        chk("rr_drained_idle", 32'(idle), 32'd1);

        // Four back-to-back reads to addresses 0..3.
        tick();
        for (int c = 0; c <= RDL + 6; c++) begin
            rd_req  = (c < 4);
            rd_addr = AW'(c);
            mid();
            chk("b2b_gnt", 32'(rd_gnt), 32'(c < 4));
            chk("b2b_valid", 32'(rd_data_valid), 32'(c >= RDL + 2 && c < RDL + 6));
            if (c >= RDL + 2 && c < RDL + 6)
                chk("b2b_data", 32'(rd_data), 32'h1224 + 32'(c - (RDL + 2)));
            tick();
        end
        rd_req = 1'b0;
        mid();
        chk("b2b_idle", 32'(idle), 32'd1);

        // Freeze one cycle after a read grant.
        tick();
        rd_req = 1'b1; rd_addr = 20'h00005;
        mid();
        chk("frz_first_gnt", 32'(rd_gnt), 32'd1);
        tick();
        for (int c = 1; c <= RDL + 3; c++) begin
            rd_req = 1'b1; wr_req = 1'b1; pad_req = 1'b1; freeze = 1'b1;
            mid();
            chk("frz_no_gnt", 32'({pad_gnt, wr_gnt, rd_gnt}), 32'd0);
            chk("frz_glb_en", 32'(glb_en), 32'(c == 1));
            chk("frz_valid", 32'(rd_data_valid), 32'(c == RDL + 2));
            if (c == RDL + 2) chk("frz_data", 32'(rd_data), 32'h1229);
            if (c == RDL + 3) chk("frz_idle", 32'(idle), 32'd1);
            tick();
        end
        rd_req = 1'b0; wr_req = 1'b0; pad_req = 1'b0; freeze = 1'b0;

        // Reset with two reads in flight.
        tick();
        rd_req = 1'b1; rd_addr = 20'h00008;
        mid();
        chk("rst_rd0_gnt", 32'(rd_gnt), 32'd1);
        tick();
        rd_addr = 20'h00009;
        mid();
        chk("rst_rd1_gnt", 32'(rd_gnt), 32'd1);
        tick();
        rd_req = 1'b0;
        mid();
        reset_n = 1'b0;
        #1;
        chk_reset_outputs("midrst");
        tick(); tick();
        reset_n = 1'b1;
        for (int c = 0; c < RDL + 4; c++) begin
            mid();
            chk("postrst_no_valid", 32'(rd_data_valid), 32'd0);
            tick();
        end
        rd_req = 1'b1; wr_req = 1'b1; pad_req = 1'b1;
        mid();
`ifdef LRN_ARB_FIXED_PRIO_EN
        chk("postrst_first_gnt", 32'({pad_gnt, wr_gnt, rd_gnt}), 32'b010);
`else
        chk("postrst_first_gnt", 32'({pad_gnt, wr_gnt, rd_gnt}), 32'b001);
`endif
        tick();
        rd_req = 1'b0; wr_req = 1'b0; pad_req = 1'b0;
        mid();
        chk("postrst_glb_en", 32'(glb_en), 32'd1);
`ifdef LRN_ARB_FIXED_PRIO_EN
        chk("postrst_glb_we", 32'(glb_we), 32'd1);
`else
        chk("postrst_glb_we", 32'(glb_we), 32'd0);
`endif
        repeat (RDL + 4) tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
